// File: rtl/vga_timing.sv
// vga_timing -- VGA raster timing generator (default 800x600@60, 40 MHz).
//
// Produces the registered timing bus consumed by the first video pipeline
// stage. Counts advance only on cycles with ce=1. Blank and sync flags are
// decoded from the next-count values, so each flag is registered on the same
// edge as the count it describes and there is no skew between them.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous reset, active low
//   ce           pixel enable
//   hcount       pixel column, 0..H_TOTAL-1 (11 bits)
//   hsync        horizontal sync, active level SYNC_POL
//   hblnk        1 while hcount >= H_ACTIVE
//   vcount       line, 0..V_TOTAL-1 (11 bits)
//   vsync        vertical sync, active level SYNC_POL, line aligned
//   vblnk        1 while vcount >= V_ACTIVE
//   frame_start  one-cycle pulse when the counters wrap to (0,0)
//   frame_cnt    16-bit frame counter (only with VGA_TIMING_FRAME_CNT_EN)
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
// H_TOTAL and V_TOTAL must not exceed 2048.

module vga_timing #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    // Inclusive sync windows.
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next = vcount;
        if (h_wrap)
            v_next = v_wrap ? 11'd0 : vcount + 11'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt   <= 16'd0;
`endif
        end else begin
            // The pulse lasts one clock even if ce drops right after it.
            frame_start <= 1'b0;
            if (ce) begin
                hcount      <= h_next;
                vcount      <= v_next;
                hblnk       <= (h_next >= H_ACT);
                vblnk       <= (v_next >= V_ACT);
                hsync       <= (h_next >= H_SS && h_next <= H_SE) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (v_next >= V_SS && v_next <= V_SE) ? SYNC_POL : ~SYNC_POL;
                frame_start <= h_wrap & v_wrap;
`ifdef VGA_TIMING_FRAME_CNT_EN
                if (h_wrap && v_wrap)
                    frame_cnt <= frame_cnt + 16'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing -- directed, table-driven bench for vga_timing.
//
// Two instances share clk/rst/ce: "big" uses the default 800x600 timing for
// line-level checks; "small" uses a 16x11 raster with active-low syncs so that
// whole frames (176 enabled cycles) fit in a short run.
// small: H 8/2/3/3 (hsync active h=10..12), V 6/1/2/2 (vsync active v=7..8).

module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] b_h, b_v, s_h, s_v;
    logic        b_hs, b_hb, b_vs, b_vb, b_fs;
    logic        s_hs, s_hb, s_vs, s_vb, s_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] b_fc, s_fc;
`endif

    vga_timing u_big (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(b_h), .hsync(b_hs), .hblnk(b_hb),
        .vcount(b_v), .vsync(b_vs), .vblnk(b_vb),
        .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.frame_cnt(b_fc)
`endif
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(s_h), .hsync(s_hs), .hblnk(s_hb),
        .vcount(s_v), .vsync(s_vs), .vblnk(s_vb),
        .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.frame_cnt(s_fc)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;   // enabled edges since the last reset release

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int tgt);
        while (k < tgt) begin
            tick();
            k++;
        end
    endtask

    typedef struct {
        int k;
        bit sel;   // 0 = big, 1 = small
        int h;
        int v;
        bit hs, hb, vs, vb, fs;
        int fc;
    } vec_t;

    function automatic vec_t mk(int kk, bit sel, int h, int v,
                                bit hs, bit hb, bit vs, bit vb, bit fs, int fc);
        vec_t r;
        r.k = kk; r.sel = sel; r.h = h; r.v = v;
        r.hs = hs; r.hb = hb; r.vs = vs; r.vb = vb; r.fs = fs; r.fc = fc;
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " b_h"},  b_h, 0);  chk({tag, " b_v"},  b_v, 0);
        chk({tag, " b_hs"}, b_hs, 0); chk({tag, " b_vs"}, b_vs, 0);
        chk({tag, " b_hb"}, b_hb, 0); chk({tag, " b_vb"}, b_vb, 0);
        chk({tag, " b_fs"}, b_fs, 0);
        chk({tag, " s_h"},  s_h, 0);  chk({tag, " s_v"},  s_v, 0);
        chk({tag, " s_hs"}, s_hs, 1); chk({tag, " s_vs"}, s_vs, 1);
        chk({tag, " s_hb"}, s_hb, 0); chk({tag, " s_vb"}, s_vb, 0);
        chk({tag, " s_fs"}, s_fs, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, " b_fc"}, b_fc, 0); chk({tag, " s_fc"}, s_fc, 0);
`endif
    endtask

    vec_t tbl[$];

    initial begin
        //                k     sel h     v   hs hb vs vb fs fc
        tbl.push_back(mk(1,    0, 1,    0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9,    1, 9,    0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(10,   1, 10,   0,  0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(12,   1, 12,   0,  0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(13,   1, 13,   0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(16,   1, 0,    1,  1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(111,  1, 15,   6,  1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(112,  1, 0,    7,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(143,  1, 15,   8,  1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(144,  1, 0,    9,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(175,  1, 15,   10, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(176,  1, 0,    0,  1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(177,  1, 1,    0,  1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(352,  1, 0,    0,  1, 0, 1, 0, 1, 2));
        tbl.push_back(mk(799,  0, 799,  0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(800,  0, 800,  0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(839,  0, 839,  0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(840,  0, 840,  0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(967,  0, 967,  0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(968,  0, 968,  0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1055, 0, 1055, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1056, 0, 0,    1,  0, 0, 0, 0, 0, 0));

        // Reset held for 5 edges.
        #2 rst = 1'b0;
        #1 chk_reset("async_rst0");
        repeat (5) tick();
        chk_reset("rst_hold");
        rst = 1'b1;
        ce  = 1'b1;
        k   = 0;

        foreach (tbl[i]) begin
            string t;
            run_to(tbl[i].k);
            t = $sformatf("k%0d %s", tbl[i].k, tbl[i].sel ? "small" : "big");
            if (tbl[i].sel) begin
                chk({t, " hcount"}, s_h, tbl[i].h);  chk({t, " vcount"}, s_v, tbl[i].v);
                chk({t, " hsync"},  s_hs, tbl[i].hs); chk({t, " hblnk"},  s_hb, tbl[i].hb);
                chk({t, " vsync"},  s_vs, tbl[i].vs); chk({t, " vblnk"},  s_vb, tbl[i].vb);
                chk({t, " frame_start"}, s_fs, tbl[i].fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
                chk({t, " frame_cnt"}, s_fc, tbl[i].fc);
`endif
            end else begin
                chk({t, " hcount"}, b_h, tbl[i].h);  chk({t, " vcount"}, b_v, tbl[i].v);
                chk({t, " hsync"},  b_hs, tbl[i].hs); chk({t, " hblnk"},  b_hb, tbl[i].hb);
                chk({t, " vsync"},  b_vs, tbl[i].vs); chk({t, " vblnk"},  b_vb, tbl[i].vb);
                chk({t, " frame_start"}, b_fs, tbl[i].fs);
            end
        end

        // ce gating: freeze at big hcount=500 for 7 cycles.
        run_to(1556);
        chk("ce pre h", b_h, 500);
        ce = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("ce hold%0d h", i), b_h, 500);
            chk($sformatf("ce hold%0d v", i), b_v, 1);
            chk($sformatf("ce hold%0d s_h", i), s_h, 1556 % 16);
        end
        ce = 1'b1;
        tick(); k++;
        chk("ce resume h", b_h, 501);

        // frame_start clears on the next edge even with ce=0.
        run_to(1760);
        chk("fs pulse", s_fs, 1);
        ce = 1'b0;
        tick();
        chk("fs ce0 clear", s_fs, 0);
        chk("fs ce0 s_h", s_h, 0);
        chk("fs ce0 s_v", s_v, 0);
        chk("fs ce0 b_h", b_h, 704);
        ce = 1'b1;

        // Mid-frame async reset at small (v3,h7), between edges.
        run_to(1815);
        chk("mid pre s_h", s_h, 7);
        chk("mid pre s_v", s_v, 3);
        #2 rst = 1'b0;
        #1 chk_reset("mid_async");
        tick();
        tick();
        rst = 1'b1;
        k   = 0;
        for (int i = 1; i < 176; i++) begin
            tick(); k++;
            chk($sformatf("post_rst k%0d no fs", i), s_fs, 0);
        end
        tick(); k++;
        chk("post_rst frame fs", s_fs, 1);
        chk("post_rst frame h", s_h, 0);
        chk("post_rst frame v", s_v, 0);
        chk("post_rst big h", b_h, 176);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("post_rst frame_cnt", s_fc, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Source of the VGA raster timing bus: hcount, hsync, hblnk, vcount, vsync and vblnk.
- Drives the first stage of the video pipeline. Downstream delay and draw stages consume this bus one register stage at a time.
- Default mode is 800x600@60 with a 40 MHz pixel clock and positive syncs.
- Every output is registered and mutually consistent in the same cycle.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 628
SYNC_POL, 1, active level of hsync/vsync (1 = active-high)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
ce  in  1  pixel enable; timing advances only on cycles with ce=1
hcount  out  11  current pixel column, 0..H_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
hblnk  out  1  1 while hcount >= H_ACTIVE
vcount  out  11  current line, 0..V_TOTAL-1
vsync  out  1  vertical sync, level per SYNC_POL
vblnk  out  1  1 while vcount >= V_ACTIVE
frame_start  out  1  one-cycle pulse when counters wrap to (0,0)

Behaviour:
- Reset: rst=0 forces outputs immediately, without a clock edge:
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0.
  - hsync and vsync go to their inactive level (~SYNC_POL).
- Reset release: counting starts on the first rising clk edge with rst=1 and ce=1.
- Counting:
  - Each clk edge with ce=1: hcount <= (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - vcount changes only on the hcount wrap: vcount <= (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - ce=0: all outputs hold their values; frame_start is forced to 0.
- Decode:
  - hblnk, hsync, vblnk and vsync are computed from the next-count values and registered in the same edge as the counts.
  - Result: zero skew between each count and its flags; latency 0 relative to the count.
- Sync windows:
  - hsync active for H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1.
  - vsync active for V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1.
  - vsync is line-aligned: it changes on the same edge as vcount.
- frame_start:
  - 1 for exactly the cycle in which (vcount,hcount) became (0,0) through a wrap from (V_TOTAL-1,H_TOTAL-1).
  - Not asserted by reset itself.
  - Cleared on the next clk edge regardless of ce.
- Widths: counters are 11 bits; H_TOTAL and V_TOTAL must be <= 2048. Compares are unsigned; counters never exceed TOTAL-1.
- Reset mid-frame: an async abort is legal at any time; the next frame restarts from (0,0) with no partial pulses.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined:
  - Adds output port frame_cnt [15:0], reset 0.
  - Increments by 1, with natural 16-bit wrap 65535->0, on the same edge that asserts frame_start.
  - Used by game logic for animation ticks.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release with ce=1.
  - During reset: hcount=0, vcount=0, hsync=vsync=0, blanks 0, frame_start=0.
  - First edge after release: hcount=1.
- Line wrap: run from reset, ce=1.
  - hcount goes 1055 -> 0 on the same edge vcount goes 0 -> 1.
  - hblnk=1 for hcount 800..1055.
  - hsync=1 exactly for hcount 840..967 (128 cycles).
- Vertical decode:
  - vblnk=1 for vcount 600..627.
  - vsync=1 for vcount 601..604, rising on the edge where hcount becomes 0.
- Frame wrap:
  - At (627,1055) the next edge gives (0,0) with frame_start=1 for exactly 1 cycle.
  - Pulse period is 663168 cycles.
  - With VGA_TIMING_FRAME_CNT_EN, frame_cnt goes 0 -> 1 on that edge.
- ce gating: drop ce at hcount=500 for 7 cycles -> all outputs frozen at hcount=500; resumes 501 after ce=1.
- Mid-frame reset: assert rst=0 asynchronously (between edges) at vcount=300, hcount=700.
  - Outputs go to reset values before the next edge.
  - After release, no frame_start pulse until a full frame completes.
